rgb_sram_writer: RTL
====================

# rgb_sram_writer

Downstream stage of the YUV→RGB colourspace converter. Accepts one even/odd pixel pair per handshake as signed 32-bit fixed-point R/G/B accumulators, clips each channel to 8 bits, buffers up to two pairs, and writes them to SRAM as three packed 16-bit words per pair starting at the RGB region. Sits between the converter's multiplier datapath and the shared SRAM controller port, writing only while granted the bus.

## Interface
Parameters:
- RGB_OFFSET, 18'd146944: SRAM word address of the first RGB word.
- NUM_PAIRS, 18'd38400: pixel pairs per frame (320x240/2).
- FRAC_BITS, 16: fractional bits in the input accumulators.

Ports:
- Clock_50  in  1  system clock, all logic on posedge.
- Resetn  in  1  active-low reset; one clock; reset is synchronous and active-low.
- start  in  1  single-cycle pulse; begins or restarts a frame.
- pair_valid  in  1  upstream has a pair on the data inputs.
- pair_ready  out  1  block accepts a pair this cycle.
- r_even, g_even, b_even, r_odd, g_odd, b_odd  in  32 each  signed accumulators.
- sram_grant  in  1  block may drive a write this cycle.
- SRAM_address  out  18  write address to SRAM controller.
- SRAM_write_data  out  16  write data.
- SRAM_we_n  out  1  active-low write enable.
- busy  out  1  frame in progress.
- done  out  1  level; all NUM_PAIRS pairs written.

## Operation
- Clip per channel (v signed 32): v[31]=1 → 0; else any of v[30:FRAC_BITS+8] set → 255; else v[FRAC_BITS+7:FRAC_BITS].
- Clipping applied on push; FIFO stores 48-bit clipped pairs {Re,Ge,Be,Ro,Go,Bo}.
- FIFO: 2 entries, 2-bit count. Push when pair_valid && pair_ready. pair_ready = busy && count<2 (combinational). Simultaneous push and pop: count unchanged, ordering preserved.
- Packing per pair: word0 {Re,Ge}, word1 {Be,Ro}, word2 {Go,Bo}; high byte first.
- Address: word address register, loaded with RGB_OFFSET on start, +1 per issued word. Last address RGB_OFFSET+3*NUM_PAIRS-1 = 262143 (default); no wrap past it.
- FSM states: S_WR_IDLE, S_WR_W0, S_WR_W1, S_WR_W2, S_WR_DONE.
  - S_WR_IDLE: start → S_WR_W0, busy=1, done=0, FIFO cleared, pair counter=0.
  - S_WR_W0/W1: if FIFO non-empty and sram_grant: issue word, advance. Else SRAM_we_n=1, hold.
  - S_WR_W2: on issue, pop FIFO, pair counter+1; if counter was NUM_PAIRS-1 → S_WR_DONE, else S_WR_W0.
  - S_WR_DONE: busy=0, done=1, pair_ready=0; start → restart as from idle.
- start in any non-idle state: abort current frame, clear FIFO and counters, restart at S_WR_W0; partial pair writes are not completed.
- sram_grant deasserted mid-pair: stall in current word state; remaining words issue when grant returns.

## Timing
- Reset values: SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, busy=0, done=0, pair_ready=0; FSM S_WR_IDLE, FIFO empty.
- SRAM_address/SRAM_write_data/SRAM_we_n registered; SRAM_we_n=0 for exactly one cycle per word.
- Latency: pair pushed at edge k → word0 on outputs after edge k+1 (grant high), word1 k+2, word2 k+3.
- Throughput: one pair per 3 cycles with continuous grant; pair_ready never drops under sustained 1-per-3 input.
- done rises the cycle after the final word2 is issued.
- Resetn low mid-frame: all state to reset values at next edge; no further writes.

## Structure
- Shared package: state enum type (S_WR_*), RGB_OFFSET, NUM_PAIRS, clip function.
- One sub-module natural: rgb_clip8 (combinational 32→8 clip, instantiated six times).
- FIFO and FSM inline.

## Test plan
- Single pair, grant high: R/G/B even = 100<<16, 200<<16, 50<<16; odd = 1<<16, 2<<16, 3<<16 → writes 0x64C8 @146944, 0x3201 @146945, 0x0203 @146946; we_n low 3 consecutive cycles.
- Clipping: r_even=-5, g_even=300<<16, b_even=0x00FF_FFFF → bytes 0x00, 0xFF, 0xFF.
- Grant toggling every other cycle with two queued pairs → six writes, correct order, no word dropped/duplicated, we_n=1 whenever grant=0.
- Backpressure: pair_valid held high, grant low → pair_ready drops after 2 pushes; grant high → resumes.
- Full frame NUM_PAIRS=4 override → 12 writes, last address RGB_OFFSET+11, done=1, busy=0, pair_ready=0.
- Resetn low after word1 of pair 0 → next cycle we_n=1, address 0, done 0; restart with start rewrites from RGB_OFFSET.

Source files
------------

// File: rtl/rgb_sram_writer_pkg.sv
// Shared types, defaults and the 8-bit channel clip used by the RGB SRAM writer.
package rgb_sram_writer_pkg;

    // Write-side FSM states: one state per packed word of a pixel pair
    typedef enum logic [2:0] {
        S_WR_IDLE,
        S_WR_W0,
        S_WR_W1,
        S_WR_W2,
        S_WR_DONE
    } wr_state_t;

    localparam logic [17:0] DEF_RGB_OFFSET = 18'd146944;
    localparam logic [17:0] DEF_NUM_PAIRS  = 18'd38400;
    localparam int          DEF_FRAC_BITS  = 16;

    // Clipped pair layout: {Re, Ge, Be, Ro, Go, Bo}, eight bits each
    localparam int PAIR_W = 48;

    // Clip a signed fixed-point accumulator to 0..255.
    // Negative values floor at 0; any integer bit above the low byte saturates at 255.
    function automatic logic [7:0] clip8(input logic signed [31:0] v, input int frac);
        logic [31:0] shifted;
        shifted = $unsigned(v) >> frac;
        if (v[31]) begin
            return 8'd0;
        end else if (|shifted[31:8]) begin
            return 8'hFF;
        end else begin
            return shifted[7:0];
        end
    endfunction

endpackage

// File: rtl/rgb_sram_writer_clip8.sv
// Combinational 32-bit signed accumulator to 8-bit channel clip.
module rgb_clip8
    import rgb_sram_writer_pkg::*;
#(
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic signed [31:0] value,
    output logic        [7:0]  clipped
);

    assign clipped = clip8(value, FRAC_BITS);

endmodule

// File: rtl/rgb_sram_writer.sv
// Clips RGB pixel pairs to 8 bits, buffers two pairs and writes them to SRAM
// as three packed 16-bit words per pair while the bus is granted.
module rgb_sram_writer
    import rgb_sram_writer_pkg::*;
#(
    parameter logic [17:0] RGB_OFFSET = DEF_RGB_OFFSET,
    parameter logic [17:0] NUM_PAIRS  = DEF_NUM_PAIRS,
    parameter int          FRAC_BITS  = DEF_FRAC_BITS
) (
    input  logic               Clock_50,
    input  logic               Resetn,
    input  logic               start,
    input  logic               pair_valid,
    output logic               pair_ready,
    input  logic signed [31:0] r_even,
    input  logic signed [31:0] g_even,
    input  logic signed [31:0] b_even,
    input  logic signed [31:0] r_odd,
    input  logic signed [31:0] g_odd,
    input  logic signed [31:0] b_odd,
    input  logic               sram_grant,
    output logic        [17:0] SRAM_address,
    output logic        [15:0] SRAM_write_data,
    output logic               SRAM_we_n,
    output logic               busy,
    output logic               done
);

    // Final word address of the frame; the address register never moves past it
    localparam logic [17:0] LAST_ADDR = 18'(RGB_OFFSET + 18'd3 * NUM_PAIRS - 18'd1);
    localparam logic [17:0] LAST_PAIR = 18'(NUM_PAIRS - 18'd1);

    wr_state_t          state_reg;
    logic [17:0]        addr_reg;
    logic [17:0]        pair_cnt_reg;

    logic [PAIR_W-1:0]  fifo_mem [2];
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [1:0]         count_reg;

    logic signed [31:0] chan_in   [6];
    logic        [7:0]  chan_clip [6];
    logic [PAIR_W-1:0]  push_pair;
    logic [PAIR_W-1:0]  head_pair;
    logic [15:0]        word_next;
    logic               in_word_state;
    logic               issue;
    logic               push;
    logic               pop;

    // Channel order matches the stored pair layout, even pixel first
    assign chan_in[0] = r_even;
    assign chan_in[1] = g_even;
    assign chan_in[2] = b_even;
    assign chan_in[3] = r_odd;
    assign chan_in[4] = g_odd;
    assign chan_in[5] = b_odd;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_clip
            rgb_clip8 #(
                .FRAC_BITS(FRAC_BITS)
            ) u_clip (
                .value  (chan_in[gi]),
                .clipped(chan_clip[gi])
            );
        end
    endgenerate

    assign push_pair = {chan_clip[0], chan_clip[1], chan_clip[2],
                        chan_clip[3], chan_clip[4], chan_clip[5]};

    // The DONE state still has busy high for its first cycle, so gate it explicitly
    assign pair_ready    = busy && (count_reg != 2'd2) && (state_reg != S_WR_DONE);
    assign push          = pair_valid && pair_ready;
    assign in_word_state = (state_reg == S_WR_W0) || (state_reg == S_WR_W1) ||
                           (state_reg == S_WR_W2);
    assign issue         = in_word_state && (count_reg != 2'd0) && sram_grant;
    assign pop           = issue && (state_reg == S_WR_W2);
    assign head_pair     = fifo_mem[rd_ptr_reg];

    // Select the packed word for the current state, high byte first
    always_comb begin
        word_next = 16'd0;
        case (state_reg)
            S_WR_W0: word_next = head_pair[47:32];
            S_WR_W1: word_next = head_pair[31:16];
            S_WR_W2: word_next = head_pair[15:0];
            default: word_next = 16'd0;
        endcase
    end

    // FIFO storage; entries are only meaningful while counted
    always_ff @(posedge Clock_50) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_pair;
        end
    end

    // Write FSM, FIFO bookkeeping and registered SRAM outputs
    always_ff @(posedge Clock_50) begin
        if (!Resetn) begin
            state_reg       <= S_WR_IDLE;
            addr_reg        <= 18'd0;
            pair_cnt_reg    <= 18'd0;
            wr_ptr_reg      <= 1'b0;
            rd_ptr_reg      <= 1'b0;
            count_reg       <= 2'd0;
            SRAM_address    <= 18'd0;
            SRAM_write_data <= 16'd0;
            SRAM_we_n       <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            SRAM_we_n <= 1'b1;
            if (start) begin
                // Begin or abort-and-restart; a partially written pair is abandoned
                state_reg    <= S_WR_W0;
                addr_reg     <= RGB_OFFSET;
                pair_cnt_reg <= 18'd0;
                wr_ptr_reg   <= 1'b0;
                rd_ptr_reg   <= 1'b0;
                count_reg    <= 2'd0;
                busy         <= 1'b1;
                done         <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= ~wr_ptr_reg;
                end
                if (pop) begin
                    rd_ptr_reg <= ~rd_ptr_reg;
                end
                if (push && !pop) begin
                    count_reg <= count_reg + 2'd1;
                end else if (!push && pop) begin
                    count_reg <= count_reg - 2'd1;
                end

                if (issue) begin
                    SRAM_we_n       <= 1'b0;
                    SRAM_address    <= addr_reg;
                    SRAM_write_data <= word_next;
                    if (addr_reg != LAST_ADDR) begin
                        addr_reg <= addr_reg + 18'd1;
                    end
                end

                case (state_reg)
                    S_WR_IDLE: begin
                        busy <= 1'b0;
                    end
                    S_WR_W0: begin
                        if (issue) begin
                            state_reg <= S_WR_W1;
                        end
                    end
                    S_WR_W1: begin
                        if (issue) begin
                            state_reg <= S_WR_W2;
                        end
                    end
                    S_WR_W2: begin
                        if (issue) begin
                            pair_cnt_reg <= pair_cnt_reg + 18'd1;
                            if (pair_cnt_reg == LAST_PAIR) begin
                                state_reg <= S_WR_DONE;
                            end else begin
                                state_reg <= S_WR_W0;
                            end
                        end
                    end
                    S_WR_DONE: begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                    default: begin
                        state_reg <= S_WR_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
